// File: rtl/p405s_icu_fill_drain_if.sv
// ICU line-fill handshake bundle: fill control, PLB read beats, array write port.
// slave = fill/drain unit, master = environment. ICU_FILL_PAR_EN adds arrWrPar.
interface p405s_icu_fill_drain_if #(
  parameter int DW = 32,
  parameter int AW = 3
);
  logic          fillStart;
  logic [0:AW-1] fillWdAddr;
  logic          fillKill;
  logic          plbRdDAck;
  logic [0:DW-1] plbRdDBus;
  logic          arrWrRdy;
  logic          arrWrVal;
  logic [0:AW-1] arrWrWdAddr;
  logic [0:DW-1] arrWrData;
  logic          critVal;
  logic [0:DW-1] critData;
  logic          fillBusy;
  logic          fillDone;
  logic          fillOvf;
`ifdef ICU_FILL_PAR_EN
  logic [0:DW/8-1] arrWrPar;
`endif

  modport slave (
    input  fillStart, fillWdAddr, fillKill,
    input  plbRdDAck, plbRdDBus, arrWrRdy,
    output arrWrVal, arrWrWdAddr, arrWrData,
`ifdef ICU_FILL_PAR_EN
    output arrWrPar,
`endif
    output critVal, critData,
    output fillBusy, fillDone, fillOvf
  );

  modport master (
    output fillStart, fillWdAddr, fillKill,
    output plbRdDAck, plbRdDBus, arrWrRdy,
    input  arrWrVal, arrWrWdAddr, arrWrData,
`ifdef ICU_FILL_PAR_EN
    input  arrWrPar,
`endif
    input  critVal, critData,
    input  fillBusy, fillDone, fillOvf
  );
endinterface

// File: rtl/p405s_icu_fill_drain.sv
// ICU line-fill consumer: captures PLB beats into a WORDS-deep line buffer,
// forwards the critical word, drains words to the array write port (val/rdy).
// Ports: CB, RST_N (async low), bus (slave modport of p405s_icu_fill_drain_if).
// Option: define ICU_FILL_PAR_EN for per-byte even parity on arrWrPar.
module p405s_icu_fill_drain #(
  parameter int DW    = 32,
  parameter int WORDS = 8,
  parameter int AW    = 3
) (
  input  logic                     CB,
  input  logic                     RST_N,
  p405s_icu_fill_drain_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t        st;
  logic [AW:0]   bcnt;
  logic [AW:0]   dcnt;
  logic [AW-1:0] base;
  logic [DW-1:0] mem [WORDS];

  logic          acc;
  logic          xfer;
  logic          start;
  logic          ovf_set;
  logic          last_beat;
  logic          last_drn;
  logic [AW:0]   bcnt_n;
  logic [AW:0]   dcnt_n;
  logic [AW-1:0] cap_idx;
  logic [AW-1:0] drn_idx;
  logic [DW-1:0] wr_data_n;

`ifdef ICU_FILL_PAR_EN
  logic [DW/8-1:0] pmem [WORDS];
  logic [DW/8-1:0] cap_par;
  logic [DW/8-1:0] wr_par_n;

  function automatic logic [DW/8-1:0] byte_par(
    input logic [DW-1:0] w
  );
    logic [DW/8-1:0] p;
    for (int i = 0; i < DW/8; i++)
      p[i] = ^w[8*i +: 8];
    return p;
  endfunction
`endif

  always_comb begin
    acc     = (st == FILL) & bus.plbRdDAck
            & ~bus.fillKill;
    xfer    = bus.arrWrVal & bus.arrWrRdy;
    start   = (st == IDLE) & bus.fillStart
            & ~bus.fillKill;
    ovf_set = bus.plbRdDAck & (st != FILL);
    bcnt_n  = bcnt + {{AW{1'b0}}, acc};
    dcnt_n  = dcnt + {{AW{1'b0}}, xfer};
    cap_idx = base + bcnt[AW-1:0];
    drn_idx = base + dcnt_n[AW-1:0];
    last_beat = acc
      & (bcnt == (AW+1)'(WORDS-1));
    last_drn  = xfer
      & (dcnt == (AW+1)'(WORDS-1));
    // Head of drain queue may be the beat
    // being captured right now.
    if (acc && cap_idx == drn_idx)
      wr_data_n = bus.plbRdDBus;
    else
      wr_data_n = mem[drn_idx];
`ifdef ICU_FILL_PAR_EN
    cap_par = byte_par(bus.plbRdDBus);
    if (acc && cap_idx == drn_idx)
      wr_par_n = cap_par;
    else
      wr_par_n = pmem[drn_idx];
`endif
  end

  always_ff @(posedge CB) begin
    if (acc) begin
      mem[cap_idx] <= bus.plbRdDBus;
`ifdef ICU_FILL_PAR_EN
      pmem[cap_idx] <= cap_par;
`endif
    end
  end

  always_ff @(posedge CB or negedge RST_N) begin
    if (!RST_N) begin
      st              <= IDLE;
      bcnt            <= '0;
      dcnt            <= '0;
      base            <= '0;
      bus.arrWrVal    <= 1'b0;
      bus.arrWrWdAddr <= '0;
      bus.arrWrData   <= '0;
`ifdef ICU_FILL_PAR_EN
      bus.arrWrPar    <= '0;
`endif
      bus.critVal     <= 1'b0;
      bus.critData    <= '0;
      bus.fillBusy    <= 1'b0;
      bus.fillDone    <= 1'b0;
      bus.fillOvf     <= 1'b0;
    end else begin
      bus.critVal  <= 1'b0;
      bus.fillDone <= 1'b0;
      if (bus.fillKill) begin
        st           <= IDLE;
        bcnt         <= '0;
        dcnt         <= '0;
        bus.arrWrVal <= 1'b0;
        bus.fillBusy <= 1'b0;
      end else begin
        bcnt            <= bcnt_n;
        dcnt            <= dcnt_n;
        bus.arrWrVal    <= (bcnt_n != dcnt_n);
        bus.arrWrWdAddr <= drn_idx;
        bus.arrWrData   <= wr_data_n;
`ifdef ICU_FILL_PAR_EN
        bus.arrWrPar    <= wr_par_n;
`endif
        if (acc && bcnt == '0) begin
          bus.critVal  <= 1'b1;
          bus.critData <= bus.plbRdDBus;
        end
        unique case (st)
          IDLE: begin
            if (start) begin
              st           <= FILL;
              base         <= bus.fillWdAddr;
              bcnt         <= '0;
              dcnt         <= '0;
              bus.fillBusy <= 1'b1;
            end
          end
          FILL: begin
            if (last_beat && last_drn) begin
              st           <= IDLE;
              bus.fillBusy <= 1'b0;
              bus.fillDone <= 1'b1;
            end else if (last_beat) begin
              st <= DRAIN;
            end
          end
          DRAIN: begin
            if (last_drn) begin
              st           <= IDLE;
              bus.fillBusy <= 1'b0;
              bus.fillDone <= 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
      // A dropped beat wins over the clear
      // from a same-cycle fillStart.
      if (ovf_set)
        bus.fillOvf <= 1'b1;
      else if (start)
        bus.fillOvf <= 1'b0;
    end
  end

endmodule
